// File: rtl/coreport_pkg.sv
// coreport_pkg: shared defaults and glitch counter limits for the GPIO input conditioning stage
package coreport_pkg;
    localparam int COREPORT_WIDTH       = 8;
    localparam int COREPORT_SYNC_STAGES = 2;
    localparam int COREPORT_SAMPLES     = 4;
    localparam int COREPORT_DIV_WIDTH   = 16;
    localparam int GLITCH_CNT_WIDTH     = 8;
    localparam logic [GLITCH_CNT_WIDTH-1:0] GLITCH_CNT_MAX = '1;
endpackage

// File: rtl/coreport_debounce_bit.sv
// coreport_debounce_bit: per-pin synchroniser, sample history, debounced level and edge pulses
// Optional glitch flag output when COREPORT_DEBOUNCE_GLITCH_CNT_EN is defined.
module coreport_debounce_bit
    import coreport_pkg::*;
#(
    parameter int SYNC_STAGES = COREPORT_SYNC_STAGES,
    parameter int SAMPLES     = COREPORT_SAMPLES
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic sample,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic glitch
`endif
);
    logic [SYNC_STAGES-1:0] sync;
    logic [SAMPLES-1:0]     hist;
    logic [SAMPLES-1:0]     new_hist;

    assign new_hist = {hist[SAMPLES-2:0], sync[SYNC_STAGES-1]};

    // bring the raw pad level into the clock domain
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], pin};
    end

    // shift in a sample per tick; flip the level only when the whole window agrees
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            hist   <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample) begin
                hist <= new_hist;
                if (&new_hist && !stable) begin
                    stable <= 1'b1;
                    rise   <= 1'b1;
                end else if (~|new_hist && stable) begin
                    stable <= 1'b0;
                    fall   <= 1'b1;
                end
            end
        end
    end

`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
    assign glitch = sample && (hist != {SAMPLES{stable}}) && (new_hist == {SAMPLES{stable}});
`endif
endmodule

// File: rtl/coreport_debounce.sv
// coreport_debounce: synchronise and debounce GPIO pad inputs on a programmable prescaler tick
// Define COREPORT_DEBOUNCE_GLITCH_CNT_EN to add a saturating rejected-glitch counter.
module coreport_debounce
    import coreport_pkg::*;
#(
    parameter int WIDTH       = COREPORT_WIDTH,
    parameter int SYNC_STAGES = COREPORT_SYNC_STAGES,
    parameter int SAMPLES     = COREPORT_SAMPLES,
    parameter int DIV_WIDTH   = COREPORT_DIV_WIDTH
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [WIDTH-1:0]     pins_i,
    output logic [WIDTH-1:0]     stable_o,
    output logic [WIDTH-1:0]     rise_o,
    output logic [WIDTH-1:0]     fall_o,
    output logic                 tick_o
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                        glitch_clr_i,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt_o
`endif
);
    logic [DIV_WIDTH-1:0] presc;
    logic                 sample;

    assign sample = tick_o & enable_i;

    // prescaler: >= compare so a lowered divisor ticks at once instead of wrapping
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            presc  <= '0;
            tick_o <= 1'b0;
        end else if (!enable_i) begin
            presc  <= '0;
            tick_o <= 1'b0;
        end else if (presc >= div_i) begin
            presc  <= '0;
            tick_o <= 1'b1;
        end else begin
            presc  <= presc + 1'b1;
            tick_o <= 1'b0;
        end
    end

`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch;

    // count ticks that rejected a glitch; clear wins over increment, saturates at max
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)                                        glitch_cnt_o <= '0;
        else if (glitch_clr_i)                             glitch_cnt_o <= '0;
        else if (|glitch && glitch_cnt_o != GLITCH_CNT_MAX) glitch_cnt_o <= glitch_cnt_o + 1'b1;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        coreport_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .SAMPLES    (SAMPLES)
        ) u_bit (
            .wb_clk(wb_clk),
            .wb_rst(wb_rst),
            .sample(sample),
            .pin   (pins_i[i]),
            .stable(stable_o[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i])
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
            ,
            .glitch(glitch[i])
`endif
        );
    end
endmodule

// File: tb/tb_coreport_debounce.sv
// tb_coreport_debounce: directed self-checking bench for coreport_debounce
module tb_coreport_debounce;
    logic        wb_clk;
    logic        wb_rst;
    logic        enable_i;
    logic [15:0] div_i;
    logic [7:0]  pins_i;
    logic [7:0]  stable_o;
    logic [7:0]  rise_o;
    logic [7:0]  fall_o;
    logic        tick_o;
    int checks = 0;
    int errors = 0;
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
    logic        glitch_clr;
    logic [7:0]  glitch_cnt;
`endif

    coreport_debounce dut (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .enable_i(enable_i),
        .div_i   (div_i),
        .pins_i  (pins_i),
        .stable_o(stable_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .tick_o  (tick_o)
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_clr_i(glitch_clr),
        .glitch_cnt_o(glitch_cnt)
`endif
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_rst   = 1'b1;
        enable_i = 1'b1;
        div_i    = 16'd0;
        pins_i   = 8'h00;
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        cyc(3);
        check("rst_stable", stable_o, 8'h00);
        check("rst_rise", rise_o, 8'h00);
        check("rst_fall", fall_o, 8'h00);
        check("rst_tick", {7'b0, tick_o}, 8'h00);
        wb_rst = 1'b0;
        cyc(10);
        check("idle_stable", stable_o, 8'h00);
        check("idle_tick", {7'b0, tick_o}, 8'h01);

        // async reset in the middle of a debounce
        pins_i = 8'hFF;
        cyc(3);
        check("pre_rst_tick", {7'b0, tick_o}, 8'h01);
        #3 wb_rst = 1'b1;
        #1;
        check("async_rst_tick", {7'b0, tick_o}, 8'h00);
        check("async_rst_stable", stable_o, 8'h00);
        check("async_rst_rise", rise_o, 8'h00);
        cyc(2);
        wb_rst = 1'b0;
        cyc(5);
        check("rel5_stable", stable_o, 8'h00);
        check("rel5_rise", rise_o, 8'h00);
        cyc(1);
        check("rel6_stable", stable_o, 8'hFF);
        check("rel6_rise", rise_o, 8'hFF);
        check("rel6_fall", fall_o, 8'h00);
        cyc(1);
        check("rel7_rise", rise_o, 8'h00);
        check("rel7_stable", stable_o, 8'hFF);

        // all pins fall
        pins_i = 8'h00;
        cyc(5);
        check("fall5_stable", stable_o, 8'hFF);
        check("fall5_fall", fall_o, 8'h00);
        cyc(1);
        check("fall6_stable", stable_o, 8'h00);
        check("fall6_fall", fall_o, 8'hFF);
        check("fall6_rise", rise_o, 8'h00);
        cyc(1);
        check("fall7_fall", fall_o, 8'h00);

        // clean step on pin 0 with div 3
        div_i  = 16'd3;
        pins_i = 8'h01;
        cyc(4);
        check("d3_tick_a", {7'b0, tick_o}, 8'h01);
        check("d3_stable_a", stable_o, 8'h00);
        cyc(1);
        check("d3_tick_b", {7'b0, tick_o}, 8'h00);
        cyc(3);
        check("d3_tick_c", {7'b0, tick_o}, 8'h01);
        cyc(8);
        check("d3_stable_pre", stable_o, 8'h00);
        check("d3_rise_pre", rise_o, 8'h00);
        cyc(1);
        check("d3_stable", stable_o, 8'h01);
        check("d3_rise", rise_o, 8'h01);
        check("d3_fall", fall_o, 8'h00);
        cyc(1);
        check("d3_rise_end", rise_o, 8'h00);

        // glitch on pin 2 rejected
        div_i = 16'd0;
        cyc(3);
        pins_i = 8'h05;
        cyc(2);
        pins_i = 8'h01;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("glitch_rise", rise_o, 8'h00);
            check("glitch_fall", fall_o, 8'h00);
        end
        check("glitch_stable", stable_o, 8'h01);
`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_one", glitch_cnt, 8'd1);
`endif

        // freeze while pins toggle
        enable_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pins_i = ~pins_i;
            cyc(1);
            check("frz_tick", {7'b0, tick_o}, 8'h00);
            check("frz_stable", stable_o, 8'h01);
            check("frz_rise", rise_o, 8'h00);
            check("frz_fall", fall_o, 8'h00);
        end
        pins_i = 8'h80;
        cyc(3);
        check("frz_hold", stable_o, 8'h01);
        enable_i = 1'b1;
        cyc(4);
        check("resume_pre", stable_o, 8'h01);
        cyc(1);
        check("resume_stable", stable_o, 8'h80);
        check("resume_rise", rise_o, 8'h80);
        check("resume_fall", fall_o, 8'h01);

        // divisor lowered below the running prescaler
        div_i = 16'd100;
        cyc(50);
        check("d100_tick", {7'b0, tick_o}, 8'h00);
        div_i = 16'd5;
        cyc(1);
        check("d5_tick_now", {7'b0, tick_o}, 8'h01);
        cyc(1);
        check("d5_tick_off", {7'b0, tick_o}, 8'h00);
        cyc(4);
        check("d5_tick_off2", {7'b0, tick_o}, 8'h00);
        cyc(1);
        check("d5_tick_6", {7'b0, tick_o}, 8'h01);
        cyc(6);
        check("d5_tick_12", {7'b0, tick_o}, 8'h01);
        check("d5_stable", stable_o, 8'h80);

`ifdef COREPORT_DEBOUNCE_GLITCH_CNT_EN
        div_i = 16'd0;
        cyc(3);
        glitch_clr = 1'b1;
        cyc(1);
        glitch_clr = 1'b0;
        check("gc_clr", glitch_cnt, 8'd0);
        pins_i = 8'h82;
        cyc(1);
        pins_i = 8'h80;
        cyc(5);
        glitch_clr = 1'b1;
        cyc(1);
        glitch_clr = 1'b0;
        check("gc_clr_prec", glitch_cnt, 8'd0);
        pins_i = 8'h82;
        cyc(1);
        pins_i = 8'h80;
        cyc(5);
        check("gc_pre_inc", glitch_cnt, 8'd0);
        cyc(1);
        check("gc_inc", glitch_cnt, 8'd1);
        for (int i = 0; i < 300; i++) begin
            pins_i = 8'h82;
            cyc(1);
            pins_i = 8'h80;
            cyc(5);
        end
        cyc(2);
        check("gc_sat", glitch_cnt, 8'd255);
        check("gc_stable", stable_o, 8'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coreport_debounce.md
Name: coreport_debounce

Overview:
Input-conditioning stage directly upstream of the GPIO port's input path. It synchronises raw pad inputs into wb_clk and debounces each bit by sampling on a programmable prescaler tick. It emits a stable level vector, which feeds the port's pin-read and interrupt-flag inputs, plus one-cycle rise/fall pulses for edge-sensitive interrupt logic.

Parameters:
WIDTH, 8, number of pins conditioned
SYNC_STAGES, 2, synchroniser flop depth (>=2)
SAMPLES, 4, consecutive agreeing samples required to change level (>=2)
DIV_WIDTH, 16, width of prescaler divisor

Ports:
wb_clk  input  1  system clock; all logic on rising edge
wb_rst  input  1  reset, asynchronous, active-high
enable_i  input  1  1 = debouncing runs; 0 = freeze
div_i  input  DIV_WIDTH  prescaler divisor; tick every div_i+1 cycles
pins_i  input  WIDTH  raw asynchronous pad inputs
stable_o  output  WIDTH  debounced level
rise_o  output  WIDTH  one-cycle pulse on debounced 0->1
fall_o  output  WIDTH  one-cycle pulse on debounced 1->0
tick_o  output  1  prescaler tick, for observability

Behaviour:
- Clock wb_clk, reset wb_rst: one clock; reset is asynchronous and active-high.
- Reset values: synchroniser flops, history, stable_o, rise_o, fall_o, prescaler and tick_o are all 0.
- Synchroniser: each bit passes through SYNC_STAGES flops. The output of the last flop is sync[i].
- Prescaler, enable_i=1:
  - if presc >= div_i then presc<=0 and tick_o<=1 for that one cycle;
  - else presc<=presc+1 and tick_o<=0.
  - div_i=0 gives a tick every cycle.
  - Lowering div_i below the current presc produces a tick on the next edge; there is no wrap through 2^DIV_WIDTH.
- enable_i=0: presc forced to 0 and tick_o=0. History and stable_o hold. rise_o/fall_o are 0.
- Per bit, on a tick edge:
  - new_hist = {hist[SAMPLES-2:0], sync[i]}; hist<=new_hist.
  - If new_hist is all ones and stable=0: stable<=1, rise<=1.
  - If new_hist is all zeros and stable=1: stable<=0, fall<=1.
  - Otherwise stable holds.
- rise_o/fall_o are registered and high for exactly one cycle, on the cycle after the tick edge that changed stable_o. They are 0 on all other cycles. rise and fall are never both high for one bit.
- Latency for a clean step with div_i=0: stable_o changes SYNC_STAGES+SAMPLES cycles after the first sampled edge of pins_i.
- Any disagreeing sample inside the window prevents a change. The count restarts naturally through the shift history.
- Asserting reset mid-debounce clears everything immediately, with no pulses. After release, a pin held high produces a rise after the full latency.

Optional Feature:
Macro COREPORT_DEBOUNCE_GLITCH_CNT_EN.
- When defined, add ports:
  - glitch_clr_i (input, 1)
  - glitch_cnt_o (output, 8)
- glitch_cnt_o increments by 1 on any tick where at least one bit had hist containing a value differing from stable, and new_hist is uniformly equal to stable. This counts a rejected glitch.
- glitch_cnt_o saturates at 255 and resets to 0.
- glitch_clr_i clears it synchronously and takes precedence over an increment in the same cycle.
- When not defined: the ports are absent and no counter logic is built.

Decomposition:
- Shared package coreport_pkg holds:
  - default constants COREPORT_WIDTH=8, COREPORT_SYNC_STAGES=2, COREPORT_SAMPLES=4;
  - glitch counter width/max constants.
- Sub-module coreport_debounce_bit contains the per-bit synchroniser, history, stable level and edge pulse registers. It is instantiated WIDTH times in a generate loop.
- The prescaler and glitch counter live in the top.

Test Plan:
- Reset: assert wb_rst asynchronously mid-cycle with pins_i=8'hFF -> all outputs 0 immediately. After release with div_i=0, stable_o=8'hFF and rise_o=8'hFF for one cycle, 6 cycles later.
- Clean step with div_i=3, pins_i[0] 0->1 -> tick_o every 4 cycles; stable_o[0] rises after 2 sync cycles plus 4 ticks; single rise_o[0] pulse; fall_o=0.
- Glitch rejection with div_i=0, pins_i[2] high for 2 cycles then low -> stable_o[2] stays 0 and no pulses. With COREPORT_DEBOUNCE_GLITCH_CNT_EN, glitch_cnt_o=1.
- Freeze: enable_i=0 while pins_i toggles for 20 cycles -> tick_o=0 and stable_o unchanged. After enable_i=1, normal debounce resumes.
- div_i change from 100 to 5 while presc=50 -> tick on next edge, then ticks every 6 cycles.
- Glitch counter: 300 glitches -> glitch_cnt_o=255. glitch_clr_i asserted in the same cycle as a glitch -> glitch_cnt_o=0.
